// File: rtl/ocd_frame_rx.sv
`default_nettype none
// ============================================================================
// ocd_frame_rx : sync-hunting frame parser driving an external CRC16 engine
// Revision     : 1.0
// ============================================================================
module ocd_frame_rx #(
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC0          = 8'h5A,
  parameter logic [7:0]  SYNC1          = 8'hA5
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        crc_sync_reset,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [15:0] crc_out,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_first,
  output logic [7:0]  frame_len,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_LEN    = 3'd2,
    S_DATA   = 3'd3,
    S_CRC_HI = 3'd4,
    S_CRC_LO = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          first_q, first_d;
  logic [7:0]    crc_hi_q, crc_hi_d;
  logic [15:0]   rx_crc_q, rx_crc_d;
  logic [TW-1:0] to_q, to_d;

  logic          crc_sync_reset_q, crc_sync_reset_d;
  logic          crc_en_q, crc_en_d;
  logic [7:0]    crc_data_q, crc_data_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_first_q, out_first_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_ok_q, frame_ok_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          in_frame;
  logic          timeout_hit;

  // The idle timer only runs once sync is found; a byte on the terminal cycle wins.
  assign in_frame    = (state_q == S_LEN) || (state_q == S_DATA) ||
                       (state_q == S_CRC_HI) || (state_q == S_CRC_LO);
  assign timeout_hit = in_frame && !rx_valid && (to_q == TO_LAST);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    first_d          = first_q;
    crc_hi_d         = crc_hi_q;
    rx_crc_d         = rx_crc_q;
    frame_len_d      = frame_len_q;
    crc_data_d       = crc_data_q;
    out_data_d       = out_data_q;
    crc_sync_reset_d = 1'b0;
    crc_en_d         = 1'b0;
    out_valid_d      = 1'b0;
    out_first_d      = 1'b0;
    frame_done_d     = 1'b0;
    frame_ok_d       = 1'b0;
    err_code_d       = ERR_NONE;
    to_d             = (rx_valid || !in_frame) ? '0 : to_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC0)) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (rx_valid) begin
          if (rx_data == SYNC1)      state_d = S_LEN;
          else if (rx_data == SYNC0) state_d = S_SYNC;
          else                       state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          frame_len_d      = rx_data;
          crc_sync_reset_d = 1'b1;
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            frame_done_d = 1'b1;
            err_code_d   = ERR_LEN;
            state_d      = S_IDLE;
          end else begin
            cnt_d   = rx_data;
            first_d = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          crc_en_d    = 1'b1;
          crc_data_d  = rx_data;
          out_valid_d = 1'b1;
          out_data_d  = rx_data;
          out_first_d = first_q;
          first_d     = 1'b0;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (rx_valid) begin
          crc_hi_d = rx_data;
          state_d  = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (rx_valid) begin
          rx_crc_d = {crc_hi_q, rx_data};
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        frame_ok_d   = (rx_crc_q == crc_out);
        err_code_d   = (rx_crc_q == crc_out) ? ERR_NONE : ERR_CRC;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      frame_done_d = 1'b1;
      frame_ok_d   = 1'b0;
      err_code_d   = ERR_TIMEOUT;
      state_d      = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      first_q          <= 1'b0;
      crc_hi_q         <= '0;
      rx_crc_q         <= '0;
      to_q             <= '0;
      crc_sync_reset_q <= 1'b0;
      crc_en_q         <= 1'b0;
      crc_data_q       <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_first_q      <= 1'b0;
      frame_len_q      <= '0;
      frame_done_q     <= 1'b0;
      frame_ok_q       <= 1'b0;
      err_code_q       <= ERR_NONE;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      first_q          <= first_d;
      crc_hi_q         <= crc_hi_d;
      rx_crc_q         <= rx_crc_d;
      to_q             <= to_d;
      crc_sync_reset_q <= crc_sync_reset_d;
      crc_en_q         <= crc_en_d;
      crc_data_q       <= crc_data_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_first_q      <= out_first_d;
      frame_len_q      <= frame_len_d;
      frame_done_q     <= frame_done_d;
      frame_ok_q       <= frame_ok_d;
      err_code_q       <= err_code_d;
    end
  end

  assign crc_sync_reset = crc_sync_reset_q;
  assign crc_en         = crc_en_q;
  assign crc_data       = crc_data_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_first      = out_first_q;
  assign frame_len      = frame_len_q;
  assign frame_done     = frame_done_q;
  assign frame_ok       = frame_ok_q;
  assign err_code       = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ocd_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_ocd_frame_rx : randomized frame stream against a cycle-indexed event model
// Revision        : 1.0
// ============================================================================
module tb_ocd_frame_rx;

  localparam int MAXL = 64;
  localparam int TOUT = 50;
  localparam logic [7:0] SY0 = 8'h5A;
  localparam logic [7:0] SY1 = 8'hA5;

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        crc_sync_reset, crc_en, out_valid, out_first, frame_done, frame_ok;
  logic [7:0]  crc_data, out_data, frame_len;
  logic [15:0] crc_out;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  ocd_frame_rx #(
    .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TOUT), .SYNC0(SY0), .SYNC1(SY1)
  ) dut (
    .clk(clk), .sync_reset(sync_reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .crc_sync_reset(crc_sync_reset), .crc_en(crc_en), .crc_data(crc_data),
    .crc_out(crc_out), .out_valid(out_valid), .out_data(out_data),
    .out_first(out_first), .frame_len(frame_len), .frame_done(frame_done),
    .frame_ok(frame_ok), .err_code(err_code)
  );

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_q(input logic [7:0] q[$]);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (q[i]) r = crc_byte(r, q[i]);
    return r;
  endfunction

  // Stand-in for the registered CRC engine on the other side of the interface
  logic [15:0] crc_reg = 16'hFFFF;
  always @(posedge clk) begin
    if (crc_sync_reset) crc_reg <= 16'hFFFF;
    else if (crc_en)    crc_reg <= crc_byte(crc_reg, crc_data);
  end
  assign crc_out = crc_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected events keyed by the cycle in which the output is visible
  logic [8:0] e_ov  [int];
  logic [2:0] e_fd  [int];
  logic [7:0] e_len [int];
  bit         e_csr [int];

  bit         chk_en = 1'b0;
  logic [7:0] cur_len = 8'h00;
  bit         ev, ed;
  logic [8:0] eo;
  int         n_ov = 0, n_first = 0, n_fd = 0, last_fd_cyc = 0;
  logic [7:0] first_data = 8'h00, last_data = 8'h00;
  logic       last_ok = 1'b0;
  logic [1:0] last_err = 2'b00;

  always @(negedge clk) begin
    if (chk_en) begin
      ev = (e_ov.exists(cyc) != 0);
      eo = ev ? e_ov[cyc] : 9'h000;
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("crc_en", {31'd0, crc_en}, {31'd0, ev});
      if (ev && out_valid) chk("out_first_data", {23'd0, out_first, out_data}, {23'd0, eo});
      if (ev && crc_en)    chk("crc_data", {24'd0, crc_data}, {24'd0, eo[7:0]});
      chk("crc_sync_reset", {31'd0, crc_sync_reset}, {31'd0, (e_csr.exists(cyc) != 0)});
      ed = (e_fd.exists(cyc) != 0);
      chk("frame_done", {31'd0, frame_done}, {31'd0, ed});
      if (ed && frame_done) chk("done_status", {29'd0, frame_ok, err_code}, {29'd0, e_fd[cyc]});
      if (e_len.exists(cyc)) cur_len = e_len[cyc];
      chk("frame_len", {24'd0, frame_len}, {24'd0, cur_len});
      if (out_valid) begin
        n_ov++;
        last_data = out_data;
        if (out_first) begin n_first++; first_data = out_data; end
      end
      if (frame_done) begin
        n_fd++; last_fd_cyc = cyc; last_ok = frame_ok; last_err = err_code;
      end
    end
  end

  task automatic tx_begin(input logic [7:0] b, input int gap, output int n);
    repeat (gap - 1) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n        = cyc + 1;
  endtask

  task automatic tx_end();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx(input logic [7:0] b, input int gap);
    int n;
    tx_begin(b, gap, n);
    tx_end();
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$],
                            input logic [15:0] trl, input int gmin, input int gmax,
                            input int long_idx);
    int n, g;
    logic ok;
    tx(SY0, $urandom_range(gmax, gmin));
    tx(SY1, $urandom_range(gmax, gmin));
    tx_begin(len, $urandom_range(gmax, gmin), n);
    e_len[n] = len;
    e_csr[n] = 1'b1;
    if (len == 8'd0 || int'(len) > MAXL) begin
      e_fd[n] = 3'b010;
      tx_end();
      return;
    end
    tx_end();
    foreach (pl[i]) begin
      g = (i == long_idx) ? TOUT : int'($urandom_range(gmax, gmin));
      tx_begin(pl[i], g, n);
      e_ov[n] = {(i == 0), pl[i]};
      tx_end();
    end
    tx(trl[15:8], $urandom_range(gmax, gmin));
    tx_begin(trl[7:0], $urandom_range(gmax, gmin), n);
    ok = (crc_q(pl) == trl);
    e_fd[n + 1] = ok ? 3'b100 : 3'b001;
    tx_end();
  endtask

  task automatic rand_payload(input int len, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  b;
    logic [15:0] c;
    int n, n22, ov0, fi0, fd0, len, kind;

    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {7'd0, crc_sync_reset, crc_en, crc_data, out_valid, out_data,
        out_first, frame_len, frame_done, frame_ok, err_code}, 32'd0);
    sync_reset = 1'b0;

    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    chk("golden_crc_123456789", {16'd0, crc_q(pl)}, 32'h29B1);

    // Good reference frame
    ov0 = n_ov; fi0 = n_first;
    send_frame(8'd9, pl, 16'h29B1, 4, 4, -1);
    repeat (4) @(negedge clk);
    chk("good_strobes", n_ov - ov0, 9);
    chk("good_first_count", n_first - fi0, 1);
    chk("good_first_data", {24'd0, first_data}, 32'h31);
    chk("good_frame_len", {24'd0, frame_len}, 32'd9);
    chk("good_crc_out", {16'd0, crc_out}, 32'h29B1);
    chk("good_status", {29'd0, last_ok, last_err}, 32'b100);

    // Corrupted trailer
    ov0 = n_ov;
    send_frame(8'd9, pl, 16'h29B0, 4, 4, -1);
    repeat (4) @(negedge clk);
    chk("crcerr_strobes", n_ov - ov0, 9);
    chk("crcerr_status", {29'd0, last_ok, last_err}, 32'b001);

    // Length boundaries
    ov0 = n_ov;
    pl = {};
    send_frame(8'd0, pl, 16'h0000, 3, 3, -1);
    repeat (4) @(negedge clk);
    chk("len0_status", {29'd0, last_ok, last_err}, 32'b010);
    chk("len0_no_payload", n_ov - ov0, 0);
    send_frame(8'h41, pl, 16'h0000, 3, 3, -1);
    repeat (4) @(negedge clk);
    chk("len65_status", {29'd0, last_ok, last_err}, 32'b010);
    rand_payload(64, pl);
    send_frame(8'd64, pl, crc_q(pl), 2, 3, -1);
    repeat (4) @(negedge clk);
    chk("len64_status", {29'd0, last_ok, last_err}, 32'b100);

    // Sync hunt
    fd0 = n_fd;
    tx(8'h5A, 3); tx(8'h5A, 3); tx(8'h13, 3);
    pl = {}; pl.push_back(8'h7E);
    send_frame(8'd1, pl, crc_q(pl), 3, 3, -1);
    repeat (4) @(negedge clk);
    chk("hunt_frames", n_fd - fd0, 1);
    chk("hunt_data", {24'd0, last_data}, 32'h7E);
    chk("hunt_status", {29'd0, last_ok, last_err}, 32'b100);

    // Stall after two of four payload bytes
    tx(SY0, 3); tx(SY1, 3);
    tx_begin(8'h04, 3, n); e_len[n] = 8'h04; e_csr[n] = 1'b1; tx_end();
    tx_begin(8'h11, 3, n); e_ov[n] = {1'b1, 8'h11}; tx_end();
    tx_begin(8'h22, 3, n22); e_ov[n22] = {1'b0, 8'h22}; e_fd[n22 + TOUT] = 3'b011; tx_end();
    repeat (TOUT + 5) @(negedge clk);
    chk("timeout_latency", last_fd_cyc - n22, TOUT);
    chk("timeout_status", {29'd0, last_ok, last_err}, 32'b011);

    // A gap of exactly TIMEOUT cycles: the byte arrives on the terminal count
    rand_payload(6, pl);
    send_frame(8'd6, pl, crc_q(pl), 2, 4, 2);
    repeat (4) @(negedge clk);
    chk("terminal_gap_status", {29'd0, last_ok, last_err}, 32'b100);

    // Reset during the third of nine payload bytes
    rand_payload(9, pl);
    tx(SY0, 3); tx(SY1, 3);
    tx_begin(8'd9, 3, n); e_len[n] = 8'd9; e_csr[n] = 1'b1; tx_end();
    for (int i = 0; i < 2; i++) begin
      tx_begin(pl[i], 3, n); e_ov[n] = {(i == 0), pl[i]}; tx_end();
    end
    tx_begin(pl[2], 3, n);
    sync_reset = 1'b1;
    e_len[n] = 8'h00;
    tx_end();
    sync_reset = 1'b0;
    chk("midreset_outputs", {7'd0, crc_sync_reset, crc_en, crc_data, out_valid, out_data,
        out_first, frame_len, frame_done, frame_ok, err_code}, 32'd0);
    fd0 = n_fd;
    repeat (20) @(negedge clk);
    chk("midreset_no_done", n_fd - fd0, 0);
    rand_payload(9, pl);
    send_frame(8'd9, pl, crc_q(pl), 2, 5, -1);
    repeat (4) @(negedge clk);
    chk("after_reset_status", {29'd0, last_ok, last_err}, 32'b100);

    // Randomized mix of frames and inter-frame noise
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(3, 0);
      case (kind)
        0: begin
          len = $urandom_range(MAXL, 1);
          rand_payload(len, pl);
          send_frame(8'(len), pl, crc_q(pl), 2, 6, -1);
        end
        1: begin
          len = $urandom_range(MAXL, 1);
          rand_payload(len, pl);
          c = crc_q(pl) ^ (16'h0001 << $urandom_range(15, 0));
          send_frame(8'(len), pl, c, 2, 6, -1);
        end
        2: begin
          pl = {};
          len = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, MAXL + 1));
          send_frame(8'(len), pl, 16'h0000, 2, 6, -1);
        end
        default: begin
          for (int k = 0; k < int'($urandom_range(8, 1)); k++) begin
            b = 8'($urandom);
            if (b == SY0) b = 8'h00;
            tx(b, $urandom_range(6, 2));
          end
        end
      endcase
    end

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
